// File: rtl/cga_trap_pkg.sv
// Shared types and constants for the CGA trap controller.
// Imported by the trap controller and its priority encoder.
package cga_trap_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WACK
  } state_t;

  localparam int IDX_PVIOL = 0;
  localparam int IDX_BRK   = 1;
  localparam int IDX_EXT0  = 2;

  localparam int PERM_W = 2;
  localparam int PERM_R = 1;
  localparam int PERM_F = 0;

endpackage

// File: rtl/cga_trap_prienc.sv
// Lowest-index-wins priority encoder.
// Produces a valid flag and the encoded index of the winner.
module cga_trap_prienc #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req,
  output logic          valid,
  output logic [IW-1:0] idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/cga_trap_ctrl.sv
// CGA trap controller: protection/breakpoint checks, pending
// collection and TRAPN/TRAP_ACK handshake to the sequencer.
module cga_trap_ctrl
  import cga_trap_pkg::*;
#(
  parameter int NSRC  = 6,
  parameter int VW    = 4,
  parameter int RINGW = 2,
  parameter int AW    = 16,
  parameter int NBRK  = 2
) (
  input  logic              TCLK,
  input  logic              RESET,
  input  logic [NSRC-1:0]   SRCN,
  input  logic [NSRC+1:0]   MASK,
  input  logic              VACC,
  input  logic              IFETCH,
  input  logic              IWRITE,
  input  logic [RINGW-1:0]  PCR,
  input  logic [RINGW-1:0]  PT_RING,
  input  logic [2:0]        PT_PERM,
  input  logic [AW-1:0]     ADDR,
  input  logic [NBRK*AW-1:0] BRK_CMP,
  input  logic [NBRK-1:0]   BRK_EN,
  input  logic              TRAP_ACK,
  output logic              TRAPN,
  output logic [VW-1:0]     TVEC,
  output logic              PVIOL,
  output logic              BRKN,
  output logic [NSRC+1:0]   PEND
);

  localparam int NT = NSRC + 2;

  if (2 ** VW < NT) begin : g_vw_chk
    $error("cga_trap_ctrl: VW too narrow for NSRC+2");
  end

  state_t        state_q, state_d;
  logic [VW-1:0] tvec_q, tvec_d;
  logic          trapn_q, trapn_d;
  logic          pviol_q, brkn_q;
  logic [NT-1:0] pend_q;

  logic          ring_bad, perm_bad, viol;
  logic          bmatch, hit, ack_ok;
  logic [NT-1:0] src, clr, elig;
  logic          win_v;
  logic [VW-1:0] win_idx;

  // A write that is also flagged as a fetch is checked as a write.
  assign ring_bad = PCR < PT_RING;
  assign perm_bad = IWRITE ? ~PT_PERM[PERM_W] :
                    IFETCH ? ~PT_PERM[PERM_F] :
                             ~PT_PERM[PERM_R];
  assign viol = VACC & (ring_bad | perm_bad);

  always_comb begin
    bmatch = 1'b0;
    for (int j = 0; j < NBRK; j++) begin
      if (BRK_EN[j] && ADDR == BRK_CMP[j*AW +: AW])
        bmatch = 1'b1;
    end
  end

  assign hit = VACC & IFETCH & bmatch;
  assign src = {~SRCN, hit, viol};

  // Index 0 is always eligible; MASK bit 0 is forced on.
  assign elig = pend_q & (MASK | NT'(1));

  cga_trap_prienc #(
    .N  (NT),
    .IW (VW)
  ) u_prienc (
    .req   (elig),
    .valid (win_v),
    .idx   (win_idx)
  );

  always_comb begin
    state_d = state_q;
    tvec_d  = tvec_q;
    trapn_d = trapn_q;
    ack_ok  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_v) begin
          tvec_d  = win_idx;
          trapn_d = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (TRAP_ACK) begin
          ack_ok  = 1'b1;
          trapn_d = 1'b1;
          state_d = WACK;
        end
      end
      WACK: begin
        if (!TRAP_ACK) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign clr = ack_ok ? (NT'(1) << tvec_q) : '0;

  always_ff @(posedge TCLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      tvec_q  <= '0;
      trapn_q <= 1'b1;
      pviol_q <= 1'b0;
      brkn_q  <= 1'b1;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      tvec_q  <= tvec_d;
      trapn_q <= trapn_d;
      pviol_q <= viol;
      brkn_q  <= ~hit;
      pend_q  <= (pend_q & ~clr) | src;
    end
  end

  assign TRAPN = trapn_q;
  assign TVEC  = tvec_q;
  assign PVIOL = pviol_q;
  assign BRKN  = brkn_q;
  assign PEND  = pend_q;

endmodule

// File: tb/tb_cga_trap_ctrl.sv
// Randomised and directed bench for cga_trap_ctrl against a
// behavioural model of the trap rules.
module tb_cga_trap_ctrl;

  localparam int NSRC = 6;
  localparam int NT   = NSRC + 2;
  localparam int VW   = 4;
  localparam int AW   = 16;
  localparam int NBRK = 2;

  logic              TCLK = 1'b0;
  logic              RESET;
  logic [NSRC-1:0]   SRCN;
  logic [NT-1:0]     MASK;
  logic              VACC, IFETCH, IWRITE;
  logic [1:0]        PCR, PT_RING;
  logic [2:0]        PT_PERM;
  logic [AW-1:0]     ADDR;
  logic [NBRK*AW-1:0] BRK_CMP;
  logic [NBRK-1:0]   BRK_EN;
  logic              TRAP_ACK;
  logic              TRAPN, PVIOL, BRKN;
  logic [VW-1:0]     TVEC;
  logic [NT-1:0]     PEND;

  int errors = 0;
  int checks = 0;

  cga_trap_ctrl #(
    .NSRC(NSRC), .VW(VW), .RINGW(2), .AW(AW), .NBRK(NBRK)
  ) dut (
    .TCLK(TCLK), .RESET(RESET), .SRCN(SRCN), .MASK(MASK),
    .VACC(VACC), .IFETCH(IFETCH), .IWRITE(IWRITE),
    .PCR(PCR), .PT_RING(PT_RING), .PT_PERM(PT_PERM),
    .ADDR(ADDR), .BRK_CMP(BRK_CMP), .BRK_EN(BRK_EN),
    .TRAP_ACK(TRAP_ACK), .TRAPN(TRAPN), .TVEC(TVEC),
    .PVIOL(PVIOL), .BRKN(BRKN), .PEND(PEND)
  );

  always #5 TCLK = ~TCLK;

  // Behavioural model: phase 0 idle, 1 requesting, 2 awaiting release
  logic          m_trapn, m_pviol, m_brkn;
  logic [VW-1:0] m_tvec;
  logic [NT-1:0] m_pend;
  int            m_phase;

  always @(posedge TCLK or posedge RESET) begin
    logic v, h, ok;
    logic [NT-1:0] nxt, el;
    if (RESET) begin
      m_trapn = 1'b1; m_tvec = '0; m_pviol = 1'b0;
      m_brkn = 1'b1; m_pend = '0; m_phase = 0;
    end else begin
      if (IWRITE) ok = PT_PERM[2];
      else if (IFETCH) ok = PT_PERM[0];
      else ok = PT_PERM[1];
      v = VACC && ((PCR < PT_RING) || !ok);
      h = 1'b0;
      for (int j = 0; j < NBRK; j++)
        if (VACC && IFETCH && BRK_EN[j] &&
            ADDR == BRK_CMP[j*AW +: AW]) h = 1'b1;
      el = m_pend & MASK;
      el[0] = m_pend[0];
      nxt = m_pend;
      if (m_phase == 1 && TRAP_ACK) nxt[m_tvec] = 1'b0;
      nxt[0] = nxt[0] | v;
      nxt[1] = nxt[1] | h;
      for (int i = 0; i < NSRC; i++)
        if (!SRCN[i]) nxt[i+2] = 1'b1;
      if (m_phase == 0) begin
        for (int i = NT - 1; i >= 0; i--)
          if (el[i]) begin
            m_tvec = VW'(i); m_trapn = 1'b0; m_phase = 1;
          end
      end else if (m_phase == 1) begin
        if (TRAP_ACK) begin m_trapn = 1'b1; m_phase = 2; end
      end else if (!TRAP_ACK) m_phase = 0;
      m_pend = nxt;
      m_pviol = v;
      m_brkn = !h;
    end
  end

  function automatic logic [14:0] obs();
    return {TRAPN, TVEC, PVIOL, BRKN, PEND};
  endfunction

  function automatic logic [14:0] expb();
    return {m_trapn, m_tvec, m_pviol, m_brkn, m_pend};
  endfunction

  task automatic step();
    @(posedge TCLK);
    #1;
  endtask

  task automatic idle_inputs();
    SRCN = '1; MASK = '1; VACC = 0; IFETCH = 0; IWRITE = 0;
    PCR = 2'd3; PT_RING = 2'd0; PT_PERM = 3'b111;
    ADDR = '0; BRK_CMP = '0; BRK_EN = '0; TRAP_ACK = 0;
  endtask

  task automatic handshake();
    TRAP_ACK = 1; step();
    TRAP_ACK = 0; step();
  endtask

  task automatic test_reset();
    idle_inputs();
    RESET = 1;
    step(); step();
    checks++;
    if (obs() !== 15'b1_0000_0_1_00000000) begin
      errors++;
      $display("FAIL reset got=%h exp=%h", obs(), 15'h4100);
    end
    RESET = 0;
    TRAP_ACK = 1; step(); TRAP_ACK = 0;
    checks++;
    if (TRAPN !== 1'b1 || obs() !== expb()) begin
      errors++;
      $display("FAIL idle_ack got=%h exp=%h", obs(), expb());
    end
  endtask

  task automatic test_ring_viol();
    PCR = 2'd1; PT_RING = 2'd2; VACC = 1; step();
    VACC = 0;
    checks++;
    if (PVIOL !== 1'b1 || PEND[0] !== 1'b1 || TRAPN !== 1'b1) begin
      errors++;
      $display("FAIL viol_pulse got=%b%b%b exp=111", PVIOL, PEND[0], TRAPN);
    end
    step();
    checks++;
    if ({PVIOL, TRAPN, TVEC} !== 6'b0_0_0000) begin
      errors++;
      $display("FAIL viol_req got=%b exp=000000", {PVIOL, TRAPN, TVEC});
    end
    TRAP_ACK = 1; step();
    checks++;
    if (PEND[0] !== 1'b0 || TRAPN !== 1'b1) begin
      errors++;
      $display("FAIL viol_ack got=%b%b exp=01", PEND[0], TRAPN);
    end
    TRAP_ACK = 0; step();
    PCR = 2'd3; PT_RING = 2'd0;
  endtask

  task automatic test_priority();
    SRCN[0] = 0; SRCN[3] = 0; step();
    SRCN = '1;
    checks++;
    if (PEND !== 8'b0010_0100) begin
      errors++;
      $display("FAIL prio_pend got=%b exp=00100100", PEND);
    end
    step();
    checks++;
    if (TRAPN !== 1'b0 || TVEC !== 4'd2) begin
      errors++;
      $display("FAIL prio_first got=%b/%0d exp=0/2", TRAPN, TVEC);
    end
    handshake();
    step();
    checks++;
    if (TRAPN !== 1'b0 || TVEC !== 4'd5) begin
      errors++;
      $display("FAIL prio_second got=%b/%0d exp=0/5", TRAPN, TVEC);
    end
    handshake();
  endtask

  task automatic test_mask();
    MASK = 8'hF7; SRCN[1] = 0; step();
    SRCN = '1;
    step();
    checks++;
    if (PEND[3] !== 1'b1 || TRAPN !== 1'b1) begin
      errors++;
      $display("FAIL mask_hold got=%b%b exp=11", PEND[3], TRAPN);
    end
    MASK = '1; step();
    checks++;
    if (TRAPN !== 1'b0 || TVEC !== 4'd3) begin
      errors++;
      $display("FAIL mask_open got=%b/%0d exp=0/3", TRAPN, TVEC);
    end
    handshake();
  endtask

  task automatic test_breakpoint();
    BRK_EN = 2'b10;
    BRK_CMP = {16'h0100, 16'h0200};
    VACC = 1; IFETCH = 1; ADDR = 16'h0200; step();
    checks++;
    if (BRKN !== 1'b1 || PEND !== 8'h00) begin
      errors++;
      $display("FAIL brk_disabled got=%b/%h exp=1/00", BRKN, PEND);
    end
    ADDR = 16'h0100; step();
    VACC = 0; IFETCH = 0;
    checks++;
    if (BRKN !== 1'b0) begin
      errors++;
      $display("FAIL brk_hit got=%b exp=0", BRKN);
    end
    step();
    checks++;
    if (BRKN !== 1'b1 || TRAPN !== 1'b0 || TVEC !== 4'd1) begin
      errors++;
      $display("FAIL brk_req got=%b%b/%0d exp=10/1", BRKN, TRAPN, TVEC);
    end
    handshake();
    VACC = 1; ADDR = 16'h0100; step();
    VACC = 0;
    checks++;
    if (BRKN !== 1'b1 || PEND !== 8'h00) begin
      errors++;
      $display("FAIL brk_read got=%b/%h exp=1/00", BRKN, PEND);
    end
    BRK_EN = '0;
  endtask

  task automatic test_retrap();
    SRCN[2] = 0; step(); step();
    checks++;
    if (TRAPN !== 1'b0 || TVEC !== 4'd4) begin
      errors++;
      $display("FAIL retrap_first got=%b/%0d exp=0/4", TRAPN, TVEC);
    end
    TRAP_ACK = 1; step();
    checks++;
    if (PEND[4] !== 1'b1 || TRAPN !== 1'b1) begin
      errors++;
      $display("FAIL retrap_keep got=%b%b exp=11", PEND[4], TRAPN);
    end
    TRAP_ACK = 0; step(); step();
    checks++;
    if (TRAPN !== 1'b0 || TVEC !== 4'd4) begin
      errors++;
      $display("FAIL retrap_again got=%b/%0d exp=0/4", TRAPN, TVEC);
    end
    SRCN = '1;
    TRAP_ACK = 1; step();
    checks++;
    if (PEND[4] !== 1'b0) begin
      errors++;
      $display("FAIL retrap_clear got=%b exp=0", PEND[4]);
    end
    TRAP_ACK = 0; step();
  endtask

  task automatic test_reset_mid_req();
    SRCN[1] = 0; step();
    SRCN = '1; step();
    checks++;
    if (TRAPN !== 1'b0 || TVEC !== 4'd3) begin
      errors++;
      $display("FAIL rst_setup got=%b/%0d exp=0/3", TRAPN, TVEC);
    end
    #3 RESET = 1;
    #1;
    checks++;
    if (TRAPN !== 1'b1 || TVEC !== 4'd0 || PEND !== 8'h00) begin
      errors++;
      $display("FAIL rst_async got=%b/%0d/%h exp=1/0/00", TRAPN, TVEC, PEND);
    end
    #2 RESET = 0;
    step();
    checks++;
    if (TRAPN !== 1'b1 || obs() !== expb()) begin
      errors++;
      $display("FAIL rst_idle got=%h exp=%h", obs(), expb());
    end
  endtask

  task automatic test_random();
    int t;
    BRK_CMP = {16'h0100, 16'h0200};
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NSRC; i++)
        SRCN[i] = ($urandom_range(9) != 0);
      MASK = NT'($urandom);
      VACC = ($urandom_range(2) == 0);
      t = $urandom_range(2);
      IWRITE = (t == 1);
      IFETCH = (t == 2);
      PCR = 2'($urandom);
      PT_RING = 2'($urandom_range(1));
      PT_PERM = ($urandom_range(3) == 0) ? 3'($urandom) : 3'b111;
      t = $urandom_range(3);
      ADDR = (t == 0) ? 16'h0100 : (t == 1) ? 16'h0200 : 16'($urandom);
      BRK_EN = 2'($urandom);
      TRAP_ACK = ($urandom_range(2) == 0);
      step();
      checks++;
      if (obs() !== expb()) begin
        errors++;
        $display("FAIL rand_%0d got=%h exp=%h", n, obs(), expb());
      end
    end
    idle_inputs();
    handshake();
  endtask

  initial begin
    RESET = 1;
    test_reset();
    test_ring_viol();
    test_priority();
    test_mask();
    test_breakpoint();
    test_retrap();
    test_reset_mid_req();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
